dh_shared_key: RTL and testbench

Responder-side Diffie-Hellman key derivation. It accepts the peer's public value over a valid/ready handshake and computes the shared secret K = peer_pub^priv_exp mod modulus using constant-time square-and-multiply. The shared key is returned on a second valid/ready handshake. The block sits downstream of the public-value generator and consumes the value produced by the other end of the exchange.

---
 rtl/dh_pkg.sv | 20 ++
 rtl/dh_shared_key_if.sv | 29 ++
 rtl/mod_mul_serial.sv | 63 ++++++
 rtl/dh_shared_key.sv | 170 +++++++++++++++++
 tb/tb_dh_shared_key.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dh_pkg.sv
// Shared types and constants for the responder-side Diffie-Hellman key block.
package dh_pkg;

  localparam int unsigned DH_WIDTH   = 32;
  localparam int unsigned MUL_CYCLES = DH_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    UPD,
    OUT
  } dh_state_t;

  // Cycles spent in MUL per exponent bit: one multiplier step per operand bit.
  function automatic int unsigned mul_cycles(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/dh_shared_key_if.sv
// Request/key handshake bundle for dh_shared_key; the block itself uses the slave modport.
interface dh_shared_key_if
  import dh_pkg::*;
#(
  parameter int unsigned WIDTH = DH_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] peer_pub;
  logic [WIDTH-1:0] priv_exp;
  logic [WIDTH-1:0] modulus;
  logic             key_valid;
  logic             key_ready;
  logic [WIDTH-1:0] key;
  logic             key_err;
  logic             busy;

  modport master (
    output in_valid, peer_pub, priv_exp, modulus, key_ready,
    input  in_ready, key_valid, key, key_err, busy
  );

  modport slave (
    input  in_valid, peer_pub, priv_exp, modulus, key_ready,
    output in_ready, key_valid, key, key_err, busy
  );

endinterface

// File: rtl/mod_mul_serial.sv
// Interleaved shift-add modular multiplier: prod = a*b mod p, one bit of b per cycle, MSB first.
// a, b and p must stay stable from start until done; a must be < p.
module mod_mul_serial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] prod,
  output logic             done
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc;
  logic [BW-1:0]    idx;
  logic             running;

  logic [WIDTH+1:0] pe;
  logic [WIDTH+1:0] ae;
  logic [WIDTH+1:0] dbl;
  logic [WIDTH+1:0] red;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] acc_nxt;

  // acc < p always, so 2*acc and red + a both stay below 2^(WIDTH+1).
  always_comb begin
    pe      = {2'b00, p};
    ae      = {2'b00, a};
    dbl     = {1'b0, acc, 1'b0};
    red     = (dbl >= pe) ? dbl - pe : dbl;
    sum     = red + (b[idx] ? ae : '0);
    acc_nxt = (sum >= pe) ? WIDTH'(sum - pe) : WIDTH'(sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      idx     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      idx     <= BW'(WIDTH - 1);
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      acc <= acc_nxt;
      if (idx == '0) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

  assign prod = acc;

endmodule

// File: rtl/dh_shared_key.sv
// Responder-side DH shared key: K = peer_pub^priv_exp mod modulus, constant-time square-and-multiply.
// Optional public-value range check enabled by defining DH_PUBCHECK_EN.
module dh_shared_key
  import dh_pkg::*;
#(
  parameter int unsigned WIDTH = DH_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  dh_shared_key_if.slave  bus
);

  localparam int unsigned    BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned    MUL_LEN  = mul_cycles(WIDTH);
  localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0]  CYC_LAST = BW'(MUL_LEN - 1);

  dh_state_t        state;
  logic             in_ready_r;
  logic             key_valid_r;
  logic [WIDTH-1:0] key_r;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] mod_r;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] base;
  logic [BW-1:0]    bitn;
  logic [BW-1:0]    cyc;

  logic             mul_start;
  logic [WIDTH-1:0] prod_r;
  logic [WIDTH-1:0] prod_b;
  logic             done_r;
  logic             done_b;
  logic             upd_go;
  logic             reject;

`ifdef DH_PUBCHECK_EN
  logic key_err_r;
  // base still holds the latched peer_pub while in LOAD.
  assign reject = (base <= WIDTH'(1)) || (base >= mod_r - WIDTH'(1));
  assign bus.key_err = key_err_r;
`else
  assign reject      = 1'b0;
  assign bus.key_err = 1'b0;
`endif

  assign upd_go = done_r & done_b;

  // Multipliers are started on the same edge that enters MUL so that each
  // bit costs exactly MUL_LEN cycles in MUL plus one in UPD.
  always_comb begin
    mul_start = 1'b0;
    case (state)
      LOAD:    mul_start = !reject;
      UPD:     mul_start = upd_go && (bitn != BIT_LAST);
      default: mul_start = 1'b0;
    endcase
  end

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul_r (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (result),
    .b     (base),
    .p     (mod_r),
    .prod  (prod_r),
    .done  (done_r)
  );

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul_b (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (base),
    .b     (base),
    .p     (mod_r),
    .prod  (prod_b),
    .done  (done_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      key_valid_r <= 1'b0;
      key_r       <= '0;
      exp_r       <= '0;
      mod_r       <= '0;
      result      <= '0;
      base        <= '0;
      bitn        <= '0;
      cyc         <= '0;
`ifdef DH_PUBCHECK_EN
      key_err_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            exp_r      <= bus.priv_exp;
            mod_r      <= bus.modulus;
            result     <= WIDTH'(1);
            base       <= bus.peer_pub;
            bitn       <= '0;
            cyc        <= '0;
            in_ready_r <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (reject) begin
            key_r       <= '0;
            key_valid_r <= 1'b1;
`ifdef DH_PUBCHECK_EN
            key_err_r   <= 1'b1;
`endif
            state       <= OUT;
          end else begin
            cyc   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          if (cyc == CYC_LAST) begin
            state <= UPD;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        UPD: begin
          if (upd_go) begin
            // Both products are always computed; only the selection depends on the bit.
            if (exp_r[bitn]) begin
              result <= prod_r;
            end
            base <= prod_b;
            if (bitn == BIT_LAST) begin
              key_r       <= exp_r[bitn] ? prod_r : result;
              key_valid_r <= 1'b1;
              state       <= OUT;
            end else begin
              bitn  <= bitn + 1'b1;
              cyc   <= '0;
              state <= MUL;
            end
          end
        end
        OUT: begin
          if (bus.key_ready) begin
            key_valid_r <= 1'b0;
            key_r       <= '0;
`ifdef DH_PUBCHECK_EN
            key_err_r   <= 1'b0;
`endif
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = !in_ready_r;
  assign bus.key_valid = key_valid_r;
  assign bus.key       = key_r;

endmodule

// File: tb/tb_dh_shared_key.sv
// Scoreboard bench for dh_shared_key: WIDTH=8 and WIDTH=32 instances, directed hand-computed vectors.
module tb_dh_shared_key;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  typedef struct {
    logic [31:0] key;
    logic        err;
    int unsigned rise;
    int unsigned hold;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];

  dh_shared_key_if #(.WIDTH(8))  b8 ();
  dh_shared_key_if #(.WIDTH(32)) b32 ();

  dh_shared_key #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  dh_shared_key #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- monitor, WIDTH=8 (also acts as key consumer) ----------------
  bit          kv_prev8 = 1'b0;
  int unsigned hold8    = 0;
  int unsigned last_hs8 = 0;
  logic [7:0]  hk8;
  logic        he8;
  exp_t        cur8;

  always @(negedge clk) begin
    if (!rst) begin
      kv_prev8     = 1'b0;
      hold8        = 0;
      b8.key_ready = 1'b0;
    end else if (b8.key_valid) begin
      if (!kv_prev8) begin
        if (q8.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_key8: got key %0d with empty scoreboard", b8.key);
          hold8 = 0;
        end else begin
          cur8 = q8.pop_front();
          check("key8", b8.key, cur8.key);
          check("key_err8", b8.key_err, cur8.err);
          check("latency8", cyc, cur8.rise);
          check("busy8", b8.busy, 1);
          hold8 = cur8.hold;
        end
        hk8 = b8.key;
        he8 = b8.key_err;
      end else begin
        check("hold_key8", b8.key, hk8);
        check("hold_err8", b8.key_err, he8);
        check("hold_in_ready8", b8.in_ready, 0);
      end
      if (hold8 > 0) begin
        b8.key_ready = 1'b0;
        hold8--;
      end else begin
        b8.key_ready = 1'b1;
        last_hs8     = cyc + 1;
      end
      kv_prev8 = 1'b1;
    end else begin
      kv_prev8     = 1'b0;
      b8.key_ready = 1'b0;
    end
  end

  // ---------------- monitor, WIDTH=32 ----------------
  bit   kv_prev32 = 1'b0;
  exp_t cur32;

  always @(negedge clk) begin
    if (!rst) begin
      kv_prev32     = 1'b0;
      b32.key_ready = 1'b0;
    end else if (b32.key_valid) begin
      if (!kv_prev32) begin
        if (q32.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_key32: got key %0d with empty scoreboard", b32.key);
        end else begin
          cur32 = q32.pop_front();
          check("key32", b32.key, cur32.key);
          check("key_err32", b32.key_err, cur32.err);
          check("latency32", cyc, cur32.rise);
        end
      end
      b32.key_ready = 1'b1;
      kv_prev32     = 1'b1;
    end else begin
      kv_prev32     = 1'b0;
      b32.key_ready = 1'b0;
    end
  end

  // ---------------- drivers (entered at a negedge) ----------------
  task automatic send8(input logic [7:0] pub, input logic [7:0] e, input logic [7:0] m,
                       input logic [7:0] k, input logic er, input int unsigned lat,
                       input int unsigned hold, input bit b2b);
    int unsigned n = 0;
    exp_t x;
    b8.peer_pub = pub;
    b8.priv_exp = e;
    b8.modulus  = m;
    b8.in_valid = 1'b1;
    while (!b8.in_ready) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        total_cnt++;
        $display("FAIL accept_timeout8: in_ready still 0 after %0d cycles", n);
        b8.in_valid = 1'b0;
        return;
      end
    end
    if (b2b) check("b2b_accept_edge8", cyc + 1, last_hs8 + 1);
    x.key  = {24'd0, k};
    x.err  = er;
    x.rise = cyc + 1 + lat;
    x.hold = hold;
    q8.push_back(x);
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.peer_pub = 8'hAA;
    b8.priv_exp = 8'h55;
    b8.modulus  = 8'h0F;
  endtask

  task automatic send32(input logic [31:0] pub, input logic [31:0] e, input logic [31:0] m,
                        input logic [31:0] k, input int unsigned lat);
    int unsigned n = 0;
    exp_t x;
    b32.peer_pub = pub;
    b32.priv_exp = e;
    b32.modulus  = m;
    b32.in_valid = 1'b1;
    while (!b32.in_ready) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        total_cnt++;
        $display("FAIL accept_timeout32: in_ready still 0 after %0d cycles", n);
        b32.in_valid = 1'b0;
        return;
      end
    end
    x.key  = k;
    x.err  = 1'b0;
    x.rise = cyc + 1 + lat;
    x.hold = 0;
    q32.push_back(x);
    @(negedge clk);
    b32.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q8.size() != 0 || q32.size() != 0 || b8.key_valid || b32.key_valid) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        total_cnt++;
        $display("FAIL drain_timeout: %0d/%0d results outstanding", q8.size(), q32.size());
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    b8.in_valid  = 1'b0;
    b8.peer_pub  = '0;
    b8.priv_exp  = '0;
    b8.modulus   = '0;
    b32.in_valid = 1'b0;
    b32.peer_pub = '0;
    b32.priv_exp = '0;
    b32.modulus  = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", b8.in_ready, 1);
    check("rst_key_valid", b8.key_valid, 0);
    check("rst_key", b8.key, 0);
    check("rst_key_err", b8.key_err, 0);
    check("rst_busy", b8.busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // 19^6 mod 23 = 2; 19^0 = 1; 19^255 = 19^13 mod 23 = 7
    send8(8'd19, 8'd6,   8'd23, 8'd2, 1'b0, 73, 0, 1'b0);
    send8(8'd19, 8'd0,   8'd23, 8'd1, 1'b0, 73, 0, 1'b0);
    send8(8'd19, 8'd255, 8'd23, 8'd7, 1'b0, 73, 0, 1'b0);
    // 3^255 = 3^5 mod 251 = 243; 200^1 = 200
    send8(8'd3,   8'd255, 8'd251, 8'd243, 1'b0, 73, 0, 1'b0);
    send8(8'd200, 8'd1,   8'd251, 8'd200, 1'b0, 73, 0, 1'b0);
    drain();

`ifdef DH_PUBCHECK_EN
    send8(8'd23, 8'd6, 8'd23, 8'd0, 1'b1, 1, 0, 1'b0);
    send8(8'd1,  8'd6, 8'd23, 8'd0, 1'b1, 1, 0, 1'b0);
    send8(8'd22, 8'd6, 8'd23, 8'd0, 1'b1, 1, 0, 1'b0);
    send8(8'd2,  8'd3, 8'd23, 8'd8, 1'b0, 73, 0, 1'b0);
`else
    send8(8'd1, 8'd77, 8'd23, 8'd1, 1'b0, 73, 0, 1'b0);
`endif
    drain();

    // Backpressure: 5^3 mod 23 = 10 held 5 cycles, next request (2^8 mod 251 = 5) waiting.
    send8(8'd5, 8'd3, 8'd23,  8'd10, 1'b0, 73, 5, 1'b0);
    send8(8'd2, 8'd8, 8'd251, 8'd5,  1'b0, 73, 0, 1'b1);
    drain();

    // 2^32 mod (2^32 - 5) = 5
    send32(32'd2, 32'd32, 32'd4294967291, 32'd5, 1057);
    drain();

    // Asynchronous reset 30 cycles into an operation.
    send8(8'd8, 8'd15, 8'd23, 8'd2, 1'b0, 73, 0, 1'b0);
    repeat (30) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_in_ready", b8.in_ready, 1);
    check("abort_key_valid", b8.key_valid, 0);
    check("abort_key", b8.key, 0);
    check("abort_key_err", b8.key_err, 0);
    check("abort_busy", b8.busy, 0);
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send8(8'd8, 8'd15, 8'd23, 8'd2, 1'b0, 73, 0, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
